// File: rtl/nes_joypad_pkg.sv
// nes_joypad_pkg: button bit positions, keyboard-to-button keycodes and port addresses
// shared by the NES joypad port controller.
package nes_joypad_pkg;
    localparam int BTN_A      = 7;
    localparam int BTN_B      = 6;
    localparam int BTN_SELECT = 5;
    localparam int BTN_START  = 4;
    localparam int BTN_UP     = 3;
    localparam int BTN_DOWN   = 2;
    localparam int BTN_LEFT   = 1;
    localparam int BTN_RIGHT  = 0;

    localparam logic [7:0] P1_KEY_UP      = 8'h1A;
    localparam logic [7:0] P1_KEY_DOWN    = 8'h16;
    localparam logic [7:0] P1_KEY_LEFT    = 8'h04;
    localparam logic [7:0] P1_KEY_RIGHT   = 8'h07;
    localparam logic [7:0] P1_KEY_A       = 8'h0F;
    localparam logic [7:0] P1_KEY_B       = 8'h0E;
    localparam logic [7:0] P1_KEY_SELECT  = 8'h0A;
    localparam logic [7:0] P1_KEY_START   = 8'h0B;
    localparam logic [7:0] P1_KEY_TURBO_A = 8'h0D;
    localparam logic [7:0] P1_KEY_TURBO_B = 8'h18;

    localparam logic [7:0] P2_KEY_UP      = 8'h52;
    localparam logic [7:0] P2_KEY_DOWN    = 8'h51;
    localparam logic [7:0] P2_KEY_LEFT    = 8'h50;
    localparam logic [7:0] P2_KEY_RIGHT   = 8'h4F;
    localparam logic [7:0] P2_KEY_A       = 8'h10;
    localparam logic [7:0] P2_KEY_B       = 8'h11;
    localparam logic [7:0] P2_KEY_SELECT  = 8'h19;
    localparam logic [7:0] P2_KEY_START   = 8'h05;

    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;

    function automatic logic has_key(input logic [31:0] kc, input logic [7:0] code);
        return (kc[7:0] == code) | (kc[15:8] == code) | (kc[23:16] == code) | (kc[31:24] == code);
    endfunction

    // A real pad cannot press both sides of the cross; games may misbehave if they see it.
    function automatic logic [7:0] mask_opposite(input logic [7:0] b);
        logic [7:0] m;
        m = b;
        if (b[BTN_UP] & b[BTN_DOWN]) begin
            m[BTN_UP]   = 1'b0;
            m[BTN_DOWN] = 1'b0;
        end
        if (b[BTN_LEFT] & b[BTN_RIGHT]) begin
            m[BTN_LEFT]  = 1'b0;
            m[BTN_RIGHT] = 1'b0;
        end
        return m;
    endfunction
endpackage

// File: rtl/joypad_shift.sv
// joypad_shift: 8-bit parallel-load shift register, MSB first, filling with 1s like a 4021.
module joypad_shift (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       shift,
    input  logic [7:0] d,
    output logic       q_msb
);
    logic [7:0] q;

    always_ff @(posedge clk) begin
        if (reset)
            q <= 8'hFF;
        else if (load)
            q <= d;
        else if (shift)
            q <= {q[6:0], 1'b1};
    end

    assign q_msb = q[7];
endmodule

// File: rtl/joypad_port_ctrl.sv
// joypad_port_ctrl: NES $4016/$4017 joypad ports driven from a USB keyboard keycode word.
// Optional turbo A/B on keys J/U is enabled by defining JOYPAD_TURBO_EN.
module joypad_port_ctrl
    import nes_joypad_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS       = 8'h40,
    parameter bit         ALLOW_OPPOSITE = 1'b0
`ifdef JOYPAD_TURBO_EN
    ,
    parameter int         TURBO_DIV      = 2_500_000
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_ce,
    input  logic [15:0] addr,
    input  logic        wren,
    input  logic        rden,
    input  logic [7:0]  din,
    input  logic [31:0] keycode,
    output logic [7:0]  dout,
    output logic        strobe_o
);
    logic [31:0] snap;
    logic [7:0]  raw1, raw2, btn1, btn2;
    logic        strobe, turbo_a, turbo_b, wr, rd, rd1, rd2, q1, q2;
    logic        unused_din;

    always_ff @(posedge clk) begin
        if (reset)
            snap <= '0;
        else
            snap <= keycode;
    end

`ifdef JOYPAD_TURBO_EN
    localparam int TW = $clog2(TURBO_DIV + 1);
    logic [TW-1:0] turbo_cnt;
    logic          turbo_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            turbo_cnt   <= '0;
            turbo_phase <= 1'b0;
        end else if (turbo_cnt == TW'(TURBO_DIV - 1)) begin
            turbo_cnt   <= '0;
            turbo_phase <= ~turbo_phase;
        end else begin
            turbo_cnt   <= turbo_cnt + TW'(1);
        end
    end

    assign turbo_a = turbo_phase & has_key(snap, P1_KEY_TURBO_A);
    assign turbo_b = turbo_phase & has_key(snap, P1_KEY_TURBO_B);
`else
    assign turbo_a = 1'b0;
    assign turbo_b = 1'b0;
`endif

    always_comb begin
        raw1 = '0;
        raw1[BTN_A]      = has_key(snap, P1_KEY_A) | turbo_a;
        raw1[BTN_B]      = has_key(snap, P1_KEY_B) | turbo_b;
        raw1[BTN_SELECT] = has_key(snap, P1_KEY_SELECT);
        raw1[BTN_START]  = has_key(snap, P1_KEY_START);
        raw1[BTN_UP]     = has_key(snap, P1_KEY_UP);
        raw1[BTN_DOWN]   = has_key(snap, P1_KEY_DOWN);
        raw1[BTN_LEFT]   = has_key(snap, P1_KEY_LEFT);
        raw1[BTN_RIGHT]  = has_key(snap, P1_KEY_RIGHT);
        raw2 = '0;
        raw2[BTN_A]      = has_key(snap, P2_KEY_A);
        raw2[BTN_B]      = has_key(snap, P2_KEY_B);
        raw2[BTN_SELECT] = has_key(snap, P2_KEY_SELECT);
        raw2[BTN_START]  = has_key(snap, P2_KEY_START);
        raw2[BTN_UP]     = has_key(snap, P2_KEY_UP);
        raw2[BTN_DOWN]   = has_key(snap, P2_KEY_DOWN);
        raw2[BTN_LEFT]   = has_key(snap, P2_KEY_LEFT);
        raw2[BTN_RIGHT]  = has_key(snap, P2_KEY_RIGHT);
    end

    assign btn1 = ALLOW_OPPOSITE ? raw1 : mask_opposite(raw1);
    assign btn2 = ALLOW_OPPOSITE ? raw2 : mask_opposite(raw2);

    // A simultaneous write suppresses the read so the shift state cannot move.
    assign wr  = cpu_ce & wren & (addr == JOY1_ADDR);
    assign rd  = cpu_ce & rden & ~wren;
    assign rd1 = rd & (addr == JOY1_ADDR);
    assign rd2 = rd & (addr == JOY2_ADDR);

    always_ff @(posedge clk) begin
        if (reset) begin
            strobe <= 1'b0;
            dout   <= 8'h00;
        end else begin
            if (wr)
                strobe <= din[0];
            if (rd1 | rd2)
                dout <= {OPEN_BUS[7:1], rd2 ? q2 : q1};
        end
    end

    joypad_shift u_port1 (
        .clk   (clk),
        .reset (reset),
        .load  (strobe),
        .shift (rd1 & ~strobe),
        .d     (btn1),
        .q_msb (q1)
    );

    joypad_shift u_port2 (
        .clk   (clk),
        .reset (reset),
        .load  (strobe),
        .shift (rd2 & ~strobe),
        .d     (btn2),
        .q_msb (q2)
    );

    assign strobe_o   = strobe;
    assign unused_din = ^din[7:1];
endmodule
